wb_line_sched: RTL

- Sequences `write2control` across a whole output feature-map tile, one line at a time.
- Takes one tile descriptor (per-MAC base address, line stride, line count, line length, mode fields) and configures `write2control` for each line in turn.
- For each line it pulses `conf_input`, waits for the writeback to start and finish, then advances the address.
- Sits between the layer-level control FSM and `write2control`; the upstream compute datapath still drives `indata_valid`/`dvalid` directly.

---
 rtl/wb_line_sched.sv | 132 +++++++++++++
 1 files changed

// File: rtl/wb_line_sched.sv
// wb_line_sched: walks write2control across an output tile one line at a time.
// Latches a tile descriptor, issues conf_input per line, waits for the
// writeback handshake (req rise, then req fall with idle), then steps each
// MAC slice address by the line stride.
module wb_line_sched #(
  parameter int X_MAC        = 4,
  parameter int ADDR_LEN     = 13,
  parameter int MAX_LINE_LEN = 10,
  parameter int LINE_CNT_LEN = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic [ADDR_LEN*X_MAC-1:0] cfg_base_addr,
  input  logic [ADDR_LEN-1:0]       cfg_stride,
  input  logic [LINE_CNT_LEN-1:0]   cfg_num_lines,
  input  logic [MAX_LINE_LEN-1:0]   cfg_linelen,
  input  logic [1:0]                cfg_valid_mac,
  input  logic                      cfg_pooled,
  input  logic [4:0]                cfg_shift_len,
  input  logic                      abort,
  output logic [ADDR_LEN*X_MAC-1:0] wc_st_addr,
  output logic [MAX_LINE_LEN-1:0]   wc_linelen,
  output logic [1:0]                wc_valid_mac,
  output logic                      wc_pooled,
  output logic [4:0]                wc_shift_len,
  output logic                      wc_conf_input,
  input  logic                      wc_req,
  input  logic                      wc_idle,
  output logic                      busy,
  output logic [LINE_CNT_LEN-1:0]   line_idx,
  output logic                      done,
  output logic                      aborted,
  output logic                      cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_NEXT,
    S_FIN
  } state_t;

  state_t                  state;
  logic                    abort_pending;
  logic [ADDR_LEN-1:0]     stride_q;
  logic [LINE_CNT_LEN-1:0] lines_left;

  // Tile sequencer: single registered FSM, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      abort_pending <= 1'b0;
      stride_q      <= '0;
      lines_left    <= '0;
      wc_st_addr    <= '0;
      wc_linelen    <= '0;
      wc_valid_mac  <= '0;
      wc_pooled     <= 1'b0;
      wc_shift_len  <= '0;
      wc_conf_input <= 1'b0;
      busy          <= 1'b0;
      line_idx      <= '0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      wc_conf_input <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      cfg_err       <= 1'b0;

      if (abort && state != S_IDLE) abort_pending <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (cfg_start) begin
            if (cfg_num_lines == '0 || cfg_linelen == '0) begin
              cfg_err <= 1'b1;
            end else begin
              stride_q     <= cfg_stride;
              lines_left   <= cfg_num_lines;
              wc_st_addr   <= cfg_base_addr;
              wc_linelen   <= cfg_linelen;
              wc_valid_mac <= cfg_valid_mac;
              wc_pooled    <= cfg_pooled;
              wc_shift_len <= cfg_shift_len;
              busy         <= 1'b1;
              line_idx     <= '0;
              state        <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wc_conf_input <= 1'b1;
          state         <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (wc_req) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!wc_req && wc_idle) state <= S_NEXT;
        end
        S_NEXT: begin
          // A live abort in this cycle ends the tile just like a pending one.
          if (abort_pending || abort || lines_left == LINE_CNT_LEN'(1)) begin
            state <= S_FIN;
          end else begin
            for (int unsigned i = 0; i < X_MAC; i++) begin
              wc_st_addr[i*ADDR_LEN +: ADDR_LEN] <=
                wc_st_addr[i*ADDR_LEN +: ADDR_LEN] + stride_q;
            end
            line_idx   <= line_idx + 1'b1;
            lines_left <= lines_left - 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_FIN: begin
          done          <= 1'b1;
          aborted       <= abort_pending;
          busy          <= 1'b0;
          abort_pending <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
